// File: rtl/regfile_dumper_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_dumper_pkg
// Description : Shared CPU constants and the dumper state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_dumper_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_SEND = 2'd2,
        ST_DONE = 2'd3
    } dump_state_e;

endpackage : regfile_dumper_pkg
`default_nettype wire

// File: rtl/regfile_dumper_if.sv
`default_nettype none
// ============================================================================
// Module      : regfile_dumper_if
// Description : Valid/ready word stream carrying dumped register values.
// Revision    : 1.0 - initial release
// ============================================================================
interface regfile_dumper_if;
    import regfile_dumper_pkg::*;

    logic                  out_valid;
    logic                  out_ready;
    logic [XLEN-1:0]       out_data;
    logic [REG_ADDR_W-1:0] out_index;
    logic                  out_last;

    // Producer side: the dumper
    modport master (
        output out_valid,
        output out_data,
        output out_index,
        output out_last,
        input  out_ready
    );

    // Consumer side: UART / VGA register view
    modport slave (
        input  out_valid,
        input  out_data,
        input  out_index,
        input  out_last,
        output out_ready
    );
endinterface : regfile_dumper_if
`default_nettype wire

// File: rtl/regfile_dumper.sv
`default_nettype none
// ============================================================================
// Module      : regfile_dumper
// Description : Walks the register file through one combinational read port
//               and streams each value with its index. hold_req tells the
//               core to suppress register writes while a dump is in flight.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_dumper
    import regfile_dumper_pkg::*;
#(
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31
) (
    input  wire logic                  clock,
    input  wire logic                  reset,
    input  wire logic                  start,
    output logic [REG_ADDR_W-1:0]      rf_addr,
    input  wire logic [XLEN-1:0]       rf_data,
    regfile_dumper_if.master           bus,
    output logic                       busy,
    output logic                       hold_req,
    output logic                       done
);

    // Illegal index ranges are rejected at elaboration time
    generate
        if (FIRST_REG < 0 || FIRST_REG > LAST_REG || LAST_REG > NUM_REGS - 1) begin : g_param_check
            $fatal(1, "regfile_dumper: need 0 <= FIRST_REG <= LAST_REG <= 31");
        end
    endgenerate

    localparam logic [REG_ADDR_W-1:0] C_FIRST = REG_ADDR_W'(FIRST_REG);
    localparam logic [REG_ADDR_W-1:0] C_LAST  = REG_ADDR_W'(LAST_REG);

    dump_state_e           state_q, state_d;
    logic [REG_ADDR_W-1:0] idx_q,   idx_d;
    logic                  valid_q, valid_d;
    logic [XLEN-1:0]       data_q,  data_d;
    logic [REG_ADDR_W-1:0] index_q, index_d;
    logic                  last_q,  last_d;
    logic                  done_q,  done_d;

    // Next-state, index walk and output-register update
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        data_d  = data_q;
        index_d = index_q;
        last_d  = last_q;
        done_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                idx_d   = C_FIRST;
                valid_d = 1'b0;
                last_d  = 1'b0;
                if (start) begin
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                // Snapshot taken here; later writes cannot disturb the word
                data_d  = rf_data;
                index_d = idx_q;
                last_d  = (idx_q == C_LAST);
                valid_d = 1'b1;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (bus.out_ready) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    if (idx_q == C_LAST) begin
                        // Rewind now so rf_addr already shows FIRST_REG in DONE/IDLE
                        idx_d   = C_FIRST;
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + REG_ADDR_W'(1);
                        state_d = ST_READ;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset wins over any in-flight word
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= C_FIRST;
            valid_q <= 1'b0;
            data_q  <= '0;
            index_q <= '0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            index_q <= index_d;
            last_q  <= last_d;
            done_q  <= done_d;
        end
    end

    assign rf_addr       = idx_q;
    assign bus.out_valid = valid_q;
    assign bus.out_data  = data_q;
    assign bus.out_index = index_q;
    assign bus.out_last  = last_q;
    assign done          = done_q;
    assign busy          = (state_q != ST_IDLE);
    assign hold_req      = busy;

endmodule : regfile_dumper
`default_nettype wire

// File: tb/tb_regfile_dumper.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_dumper
// Description : Scoreboard bench for regfile_dumper (default range plus a
//               single-register FIRST_REG=LAST_REG=31 instance).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_dumper;
    import regfile_dumper_pkg::*;

    typedef struct packed {
        logic [31:0] d;
        logic [4:0]  i;
        logic        l;
    } word_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        start_c = 1'b0;
    logic [31:0] rf [32];
    logic [4:0]  rf_addr, rf_addr_c;
    logic [31:0] rf_data, rf_data_c;
    logic        busy, hold_req, done;
    logic        busy_c, hold_req_c, done_c;

    int applied = 0;
    int miscompares = 0;
    int words_rx = 0;
    int done_cnt = 0;
    int words_rx_c = 0;
    int done_cnt_c = 0;
    word_t sb[$];
    word_t sb_c[$];

    always #5 clock = ~clock;

    regfile_dumper_if dif();
    regfile_dumper_if dif_c();

    assign rf_data   = (rf_addr   == 5'd0) ? 32'h0 : rf[rf_addr];
    assign rf_data_c = (rf_addr_c == 5'd0) ? 32'h0 : rf[rf_addr_c];

    regfile_dumper #(.FIRST_REG(0), .LAST_REG(31)) dut (
        .clock(clock), .reset(reset), .start(start),
        .rf_addr(rf_addr), .rf_data(rf_data), .bus(dif.master),
        .busy(busy), .hold_req(hold_req), .done(done)
    );

    regfile_dumper #(.FIRST_REG(31), .LAST_REG(31)) dut_c (
        .clock(clock), .reset(reset), .start(start_c),
        .rf_addr(rf_addr_c), .rf_data(rf_data_c), .bus(dif_c.master),
        .busy(busy_c), .hold_req(hold_req_c), .done(done_c)
    );

    function automatic logic [31:0] rf_init(input int r);
        return 32'(r) * 32'h01010101;
    endfunction

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Monitor for the default-range instance
    initial begin : mon_main
        word_t w;
        logic [31:0] held_d;
        logic [4:0]  held_i;
        bit held_v;
        held_v = 1'b0;
        held_d = '0;
        held_i = '0;
        forever begin
            @(negedge clock);
            if (reset) begin
                held_v = 1'b0;
            end else begin
                if (dif.out_valid && dif.out_ready) begin
                    words_rx++;
                    if (sb.size() == 0) begin
                        check("unexpected_word", 32'(dif.out_index), 32'hFFFFFFFF);
                    end else begin
                        w = sb.pop_front();
                        check("word_data",  dif.out_data,          w.d);
                        check("word_index", 32'(dif.out_index),    32'(w.i));
                        check("word_last",  32'(dif.out_last),     32'(w.l));
                    end
                end
                if (dif.out_valid && !dif.out_ready) begin
                    if (held_v) begin
                        check("stall_data",  dif.out_data,       held_d);
                        check("stall_index", 32'(dif.out_index), 32'(held_i));
                    end
                    held_d = dif.out_data;
                    held_i = dif.out_index;
                    held_v = 1'b1;
                end else begin
                    held_v = 1'b0;
                end
                if (done) done_cnt++;
            end
        end
    end

    // Monitor for the single-register instance
    initial begin : mon_corner
        word_t w;
        forever begin
            @(negedge clock);
            if (!reset) begin
                if (dif_c.out_valid && dif_c.out_ready) begin
                    words_rx_c++;
                    if (sb_c.size() == 0) begin
                        check("corner_unexpected", 32'(dif_c.out_index), 32'hFFFFFFFF);
                    end else begin
                        w = sb_c.pop_front();
                        check("corner_data",  dif_c.out_data,       w.d);
                        check("corner_index", 32'(dif_c.out_index), 32'(w.i));
                        check("corner_last",  32'(dif_c.out_last),  32'(w.l));
                    end
                end
                if (done_c) done_cnt_c++;
            end
        end
    end

    // bp: ready-low cycles per word; evt: 0 none, 1 snapshot, 2 start mid, 3 reset mid
    task automatic do_dump(input int bp, input int evt);
        int  cyc;
        int  stall;
        int  done_at;
        int  d0;
        int  w0;
        bit  seen_done;
        bit  fired;
        cyc = 0; stall = 0; done_at = -1; seen_done = 1'b0; fired = 1'b0;
        d0 = done_cnt; w0 = words_rx;
        for (int r = 0; r < 32; r++) begin
            sb.push_back('{d: rf_init(r), i: 5'(r), l: (r == 31)});
        end
        dif.out_ready = (bp == 0);
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        if (bp == 0 && evt == 0) check("busy_in_read", 32'(busy), 1);
        while (cyc < 600 && !seen_done) begin
            if (evt == 2 && fired) start = 1'b0;
            if (bp != 0) begin
                if (dif.out_valid && stall >= bp) begin
                    dif.out_ready = 1'b1;
                    stall = 0;
                end else begin
                    dif.out_ready = 1'b0;
                    if (dif.out_valid) stall++;
                end
            end
            if (dif.out_valid && !fired) begin
                if (evt == 1 && dif.out_index == 5'd7) begin
                    rf[7] = 32'hDEADBEEF;
                    fired = 1'b1;
                end
                if (evt == 2 && dif.out_index == 5'd10) begin
                    start = 1'b1;
                    fired = 1'b1;
                end
                if (evt == 3 && dif.out_index == 5'd12) begin
                    dif.out_ready = 1'b0;
                    reset = 1'b1;
                    @(posedge clock); #1;
                    reset = 1'b0;
                    check("rst_valid", 32'(dif.out_valid), 0);
                    check("rst_data",  dif.out_data, 0);
                    check("rst_index", 32'(dif.out_index), 0);
                    check("rst_last",  32'(dif.out_last), 0);
                    check("rst_busy",  32'(busy), 0);
                    check("rst_hold",  32'(hold_req), 0);
                    check("rst_done",  32'(done), 0);
                    check("rst_addr",  32'(rf_addr), 0);
                    @(negedge clock);
                    check("rst_no_done", 32'(done_cnt - d0), 0);
                    sb.delete();
                    return;
                end
            end
            if (done) begin
                seen_done = 1'b1;
                done_at = cyc;
            end else begin
                @(posedge clock); #1;
                cyc++;
            end
        end
        start = 1'b0;
        if (!seen_done) begin
            check("dump_timeout", 0, 1);
        end else begin
            if (bp == 0 && evt == 0) check("done_latency", 32'(done_at), 64);
            check("busy_in_done", 32'(busy), 1);
            @(posedge clock); #1;
            check("done_one_cycle", 32'(done), 0);
            check("busy_after_done", 32'(busy), 0);
            check("hold_after_done", 32'(hold_req), 0);
            check("words_per_dump", 32'(words_rx - w0), 32);
            check("done_pulses", 32'(done_cnt - d0), 1);
            check("sb_empty", 32'(sb.size()), 0);
        end
    endtask

    initial begin : driver
        int n;
        for (int r = 0; r < 32; r++) rf[r] = rf_init(r);
        dif.out_ready   = 1'b0;
        dif_c.out_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;

        // Reset state of both instances
        check("init_valid", 32'(dif.out_valid), 0);
        check("init_data",  dif.out_data, 0);
        check("init_index", 32'(dif.out_index), 0);
        check("init_last",  32'(dif.out_last), 0);
        check("init_busy",  32'(busy), 0);
        check("init_hold",  32'(hold_req), 0);
        check("init_done",  32'(done), 0);
        check("init_addr",  32'(rf_addr), 0);
        check("init_addr_c", 32'(rf_addr_c), 31);

        do_dump(0, 0);            // full dump, ready tied high
        do_dump(3, 0);            // backpressure: 3 cycles low per word
        do_dump(2, 1);            // snapshot: x7 rewritten during SEND
        rf[7] = rf_init(7);
        do_dump(0, 2);            // start pulsed mid-dump
        do_dump(0, 3);            // reset during SEND of index 12
        do_dump(0, 0);            // fresh dump after reset

        // Single-register corner: FIRST_REG = LAST_REG = 31
        rf[31] = 32'hCAFEF00D;
        sb_c.push_back('{d: 32'hCAFEF00D, i: 5'd31, l: 1'b1});
        dif_c.out_ready = 1'b1;
        start_c = 1'b1;
        @(posedge clock); #1;
        start_c = 1'b0;
        n = 0;
        while (!done_c && n < 20) begin
            @(posedge clock); #1;
            n++;
        end
        if (!done_c) check("corner_timeout", 0, 1);
        @(posedge clock); #1;
        check("corner_words", 32'(words_rx_c), 1);
        check("corner_done_pulses", 32'(done_cnt_c), 1);
        check("corner_sb_empty", 32'(sb_c.size()), 0);
        check("corner_busy_after", 32'(busy_c), 0);
        check("corner_addr_after", 32'(rf_addr_c), 31);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule : tb_regfile_dumper
`default_nettype wire
